// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Used by the transmit framer and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte request / serial line bundle for the UART transmitter.
// The master drives requests; the slave is the framer.
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 start;
  logic [DATA_BITS-1:0] data_in;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output data_in,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// Shared between the transmitter and the future receiver.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// tx, busy and done are all registered.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_framer_if.slave bus
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tick;

  // Held clear in IDLE so every bit period starts from zero.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (state_q == IDLE),
    .en_i  (state_q != IDLE),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q <= bus.data_in;
            par_q   <= ^bus.data_in ^ 1'(PARITY_ODD);
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= STOP;
              end
            end else begin
              // Next bit is shift_q[1]: tx is a flop, so look one ahead.
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_idx_q == STOP_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
